// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALUOp codes,
// mux-select encodings and the state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_R    = 3'b111;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_LUI  = 3'b010;
    localparam logic [2:0] ALU_ADDR = 3'b110;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_FAULT
    } state_e;

    // ALU operation used in the EXEC states, selected by the latched opcode.
    function automatic logic [2:0] exec_aluop(input logic [5:0] op);
        case (op)
            OP_RTYPE: exec_aluop = ALU_R;
            OP_ORI:   exec_aluop = ALU_OR;
            OP_ANDI:  exec_aluop = ALU_AND;
            OP_LUI:   exec_aluop = ALU_LUI;
            default:  exec_aluop = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access waits for ready; flags expiry on the cycle
// that would make the wait reach MEM_TIMEOUT. Ready in that cycle suppresses it.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_tick,
    input  logic i_ready,
    output logic o_expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_tick && !i_ready && r_count != CW'(MEM_TIMEOUT))
            r_count <= r_count + CW'(1);
    end

    assign o_expired = i_tick && !i_ready && (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with MemReady handshake, access timeout and sticky fault.
// Optional perf counters are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    OP,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               Jal,
    output logic               InstrDone,
    output logic               Fault,
    output logic [31:0]        CycleCnt,
    output logic [31:0]        RetireCnt
);
    state_e          r_state, w_next;
    logic [OP_W-1:0] r_op;
    logic            w_wait, w_expired;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_clear   (!w_wait || MemReady),
        .i_tick    (w_wait),
        .i_ready   (MemReady),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= OP;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (MemReady) w_next = S_DECODE; else if (w_expired) w_next = S_FAULT;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:                         w_next = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:                     w_next = S_ADDR;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J, OP_JAL:                     w_next = S_JUMP;
                    default:                          w_next = S_FAULT;
                endcase
            end
            S_EXEC_R: w_next = S_WB_R;
            S_EXEC_I: w_next = S_WB_I;
            S_ADDR:   w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (MemReady) w_next = S_WB_MEM; else if (w_expired) w_next = S_FAULT;
            S_MEM_WR: if (MemReady) w_next = S_FETCH;  else if (w_expired) w_next = S_FAULT;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
            default:  w_next = S_FAULT;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RT;
        ALUOp     = '0;
        PCSource  = PCS_ALU;
        Jal       = 1'b0;
        InstrDone = 1'b0;
        Fault     = 1'b0;
        // While reset is held only the fetch read request is visible, so the
        // Mealy terms cannot leak a stray IR/PC load during reset.
        if (!reset) begin
            MemRead = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                end
                S_EXEC_R, S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = (r_state == S_EXEC_R) ? SRCB_RT : SRCB_IMM;
                    ALUOp   = ALUOP_W'(exec_aluop(r_op));
                end
                S_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_W'(ALU_ADDR);
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    InstrDone = MemReady;
                end
                S_WB_R: begin
                    RegDst    = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_WB_I: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_WB_MEM: begin
                    MemtoReg  = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = ALUOP_W'(ALU_SUB);
                    PCSource  = PCS_ALUOUT;
                    PCWrite   = (r_op == OP_BEQ) ? Zero : !Zero;
                    InstrDone = 1'b1;
                end
                S_JUMP: begin
                    PCSource  = PCS_JUMP;
                    PCWrite   = 1'b1;
                    Jal       = (r_op == OP_JAL);
                    RegWrite  = (r_op == OP_JAL);
                    InstrDone = 1'b1;
                end
                default: Fault = 1'b1;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt, r_retire_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state != S_FAULT)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (InstrDone)
                r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign CycleCnt  = r_cycle_cnt;
    assign RetireCnt = r_retire_cnt;
`else
    assign CycleCnt  = 32'd0;
    assign RetireCnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase-sequence model, directed
// table, randomized instruction stream and hand-written timeout/reset sequences.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OP;
    logic        Zero, MemReady;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic        ALUSrcA, Jal, InstrDone, Fault;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [31:0] CycleCnt, RetireCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Jal(Jal), .InstrDone(InstrDone), .Fault(Fault),
        .CycleCnt(CycleCnt), .RetireCnt(RetireCnt)
    );

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       jal, done, fault;
    } outs_t;

    typedef enum int {
        P_FETCH, P_DECODE, P_EXR, P_EXI, P_WBR, P_WBI, P_ADDR,
        P_MRD, P_MWR, P_WBM, P_BR, P_JMP, P_FAULT
    } phase_t;

    outs_t act;
    assign act = '{PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, Jal, InstrDone, Fault};

    // Instruction classes as the ISA describes them.
    function automatic bit is_itype(logic [5:0] op);
        return op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F;
    endfunction

    function automatic phase_t phase_at(logic [5:0] op, int k);
        if (k == 0) return P_FETCH;
        if (k == 1) return P_DECODE;
        if (op == 6'h00) return (k == 2) ? P_EXR : P_WBR;
        if (is_itype(op)) return (k == 2) ? P_EXI : P_WBI;
        if (op == 6'h23) return (k == 2) ? P_ADDR : (k == 3) ? P_MRD : P_WBM;
        if (op == 6'h2B) return (k == 2) ? P_ADDR : P_MWR;
        if (op == 6'h04 || op == 6'h05) return P_BR;
        if (op == 6'h02 || op == 6'h03) return P_JMP;
        return P_FAULT;
    endfunction

    function automatic int len_of(logic [5:0] op);
        if (op == 6'h23) return 5;
        if (op == 6'h00 || op == 6'h2B || is_itype(op)) return 4;
        return 3;
    endfunction

    function automatic outs_t exp_out(phase_t ph, logic [5:0] op, logic z, logic mr);
        outs_t o;
        o = '0;
        case (ph)
            P_FETCH:  begin o.mrd = 1; o.srcb = 2'b01; o.aluop = 3'b100; o.irw = mr; o.pcw = mr; end
            P_DECODE: begin o.srcb = 2'b11; o.aluop = 3'b100; end
            P_EXR:    begin o.srca = 1; o.srcb = 2'b00; o.aluop = 3'b111; end
            P_EXI:    begin
                o.srca = 1; o.srcb = 2'b10;
                o.aluop = (op == 6'h0D) ? 3'b101 : (op == 6'h0C) ? 3'b000 :
                          (op == 6'h0F) ? 3'b010 : 3'b100;
            end
            P_WBR:    begin o.rdst = 1; o.rw = 1; o.done = 1; end
            P_WBI:    begin o.rw = 1; o.done = 1; end
            P_ADDR:   begin o.srca = 1; o.srcb = 2'b10; o.aluop = 3'b110; end
            P_MRD:    begin o.mrd = 1; o.iord = 1; end
            P_MWR:    begin o.mwr = 1; o.iord = 1; o.done = mr; end
            P_WBM:    begin o.m2r = 1; o.rw = 1; o.done = 1; end
            P_BR:     begin
                o.srca = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.done = 1;
                o.pcw = (op == 6'h04) ? z : !z;
            end
            P_JMP:    begin
                o.pcsrc = 2'b10; o.pcw = 1; o.done = 1;
                o.jal = (op == 6'h03); o.rw = (op == 6'h03);
            end
            default:  o.fault = 1;
        endcase
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, a, e);
        end
    endtask

    outs_t rst_vec;
    initial begin
        rst_vec = '0;
        rst_vec.mrd = 1'b1;
    end

    // Leaves the bench just after a rising edge with reset released, in FETCH.
    task automatic do_reset();
        reset = 1'b0; MemReady = 1'b0; OP = '0; Zero = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'(act), 64'(rst_vec));
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Drives one instruction through its phase sequence, waiting fw cycles for
    // MemReady in FETCH and mw cycles in the data access; returns edges consumed.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             output int cyc);
        int k = 0, fwl = fw, mwl = mw;
        bit done = 0;
        phase_t ph;
        logic mr;
        cyc = 0;
        while (!done) begin
            ph = phase_at(op, k);
            mr = 1'($urandom);
            if (ph == P_FETCH) begin mr = (fwl == 0); if (fwl > 0) fwl--; end
            else if (ph == P_MRD || ph == P_MWR) begin mr = (mwl == 0); if (mwl > 0) mwl--; end
            OP       = (ph == P_DECODE) ? op : 6'($urandom);
            Zero     = (ph == P_BR) ? z : 1'($urandom);
            MemReady = mr;
            @(negedge clk);
            chk($sformatf("op%02h_ph%0d_cyc%0d", op, ph, cyc), 64'(act), 64'(exp_out(ph, op, z, mr)));
            if (ph == P_FAULT) done = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
                if (!((ph == P_FETCH || ph == P_MRD || ph == P_MWR) && !mr)) begin
                    if (k == len_of(op) - 1) done = 1;
                    else k++;
                end
            end
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fw, mw, exp_len;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bad;
        logic [5:0] rop;
        tbl[0]  = '{6'h08, 1'b0, 0, 0, 4};   // ADDI
        tbl[1]  = '{6'h23, 1'b0, 0, 3, 8};   // LW, 3 wait cycles
        tbl[2]  = '{6'h04, 1'b1, 0, 0, 3};   // BEQ taken
        tbl[3]  = '{6'h05, 1'b1, 0, 0, 3};   // BNE not taken
        tbl[4]  = '{6'h04, 1'b0, 0, 0, 3};
        tbl[5]  = '{6'h05, 1'b0, 0, 0, 3};
        tbl[6]  = '{6'h03, 1'b0, 0, 0, 3};   // JAL
        tbl[7]  = '{6'h02, 1'b0, 0, 0, 3};   // J
        tbl[8]  = '{6'h00, 1'b0, 0, 0, 4};   // R-type
        tbl[9]  = '{6'h2B, 1'b0, 0, 0, 4};   // SW
        tbl[10] = '{6'h2B, 1'b0, 2, 5, 11};
        tbl[11] = '{6'h0D, 1'b0, 0, 0, 4};   // ORI
        tbl[12] = '{6'h0C, 1'b0, 0, 0, 4};   // ANDI
        tbl[13] = '{6'h0F, 1'b0, 0, 0, 4};   // LUI
        tbl[14] = '{6'h23, 1'b0, 1, 14, 20}; // longest legal waits

        do_reset();
        chk("perf_reset_cycle", 64'(CycleCnt), 64'd0);
        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, cyc);
            chk($sformatf("len_vec%0d", i), 64'(cyc), 64'(tbl[i].exp_len));
        end

        // Illegal opcode: fault after DECODE, held until reset.
        run_instr(6'h3F, 1'b0, 0, 0, cyc);
        chk("illegal_len", 64'(cyc), 64'd2);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            MemReady = 1'($urandom); OP = 6'($urandom); Zero = 1'($urandom);
            @(negedge clk);
            if (act !== exp_out(P_FAULT, 6'h0, 1'b0, 1'b0)) bad++;
        end
        chk("fault_hold_bad_cycles", 64'(bad), 64'd0);

        // Fetch timeout: 15 waiting cycles fault, ready on the 15th does not.
        do_reset();
        MemReady = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("timeout_cycle15_fetch", 64'({Fault, MemRead}), 64'(2'b01));
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_fault", 64'(Fault), 64'd1);
        do_reset();
        MemReady = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        MemReady = 1'b1;
        @(negedge clk);
        chk("ready_on_15_irwrite", 64'({IRWrite, Fault}), 64'(2'b10));
        @(posedge clk); #1;
        MemReady = 1'b0; OP = 6'h08;
        @(negedge clk);
        chk("ready_on_15_decode", 64'(act), 64'(exp_out(P_DECODE, 6'h08, 1'b0, 1'b0)));
        @(posedge clk); #1;

        // Reset pulsed during a stalled store drops MemWrite at once.
        do_reset();
        MemReady = 1'b1; OP = 6'h00;
        @(posedge clk); #1;
        OP = 6'h2B;
        @(posedge clk); #1;
        OP = 6'h00;
        @(posedge clk); #1;
        MemReady = 1'b0;
        @(negedge clk);
        chk("memwr_before_reset", 64'({MemWrite, IorD}), 64'(2'b11));
        #2 reset = 1'b0;
        #1 chk("memwr_async_drop", 64'(act), 64'(rst_vec));
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(6'h08, 1'b0, 0, 0, cyc);
        chk("restart_addi_len", 64'(cyc), 64'd4);

        // Perf counters after 10 zero-wait R-types.
        do_reset();
        for (int i = 0; i < 10; i++) run_instr(6'h00, 1'b0, 0, 0, cyc);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("perf_retire", 64'(RetireCnt), 64'd10);
        chk("perf_cycle", 64'(CycleCnt), 64'd40);
`else
        chk("perf_retire_tied", 64'(RetireCnt), 64'd0);
        chk("perf_cycle_tied", 64'(CycleCnt), 64'd0);
`endif

        // Random instruction stream, including arbitrary opcodes.
        for (int i = 0; i < 300; i++) begin
            int fw, mw;
            logic z;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 10))
                    0: rop = 6'h00;  1: rop = 6'h02;  2: rop = 6'h03;  3: rop = 6'h04;
                    4: rop = 6'h05;  5: rop = 6'h08;  6: rop = 6'h0C;  7: rop = 6'h0D;
                    8: rop = 6'h0F;  9: rop = 6'h23;  default: rop = 6'h2B;
                endcase
            end else begin
                rop = 6'($urandom);
            end
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
            mw = int'($urandom_range(0, 4));
            z  = 1'($urandom);
            run_instr(rop, z, fw, mw, cyc);
            if (phase_at(rop, 2) == P_FAULT) do_reset();
            else if (rop == 6'h23 || rop == 6'h2B)
                chk($sformatf("rand_len%0d", i), 64'(cyc), 64'(len_of(rop) + fw + mw));
            else
                chk($sformatf("rand_len%0d", i), 64'(cyc), 64'(len_of(rop) + fw));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
